// File: rtl/mult_seq_ovf_if.sv
// Handshake and data bundle for the sequential multiplier.
// The master drives the start strobe and operands; the slave returns the product and status.
interface mult_seq_ovf_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic             mode_unsigned;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_result_hi;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, mode_unsigned, data_operandA, data_operandB,
    input  data_result, data_result_hi, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, mode_unsigned, data_operandA, data_operandB,
    output data_result, data_result_hi, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/mult_seq_ovf.sv
// Multicycle radix-2 Booth multiplier with exact overflow detection.
// Operands are widened by one bit so a single signed recurrence handles both
// signed and unsigned modes. Latency is WIDTH+1 cycles from accept to ready.
module mult_seq_ovf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input logic          clock,
  input logic          reset,
  mult_seq_ovf_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic        [CNT_W-1:0] cnt;
  logic signed [WIDTH+1:0] acc;
  logic signed [WIDTH+1:0] mcand;
  logic        [WIDTH:0]   mult;
  logic                    q;
  logic                    mode;

  logic signed [WIDTH+1:0] acc_sum;
  logic signed [WIDTH+1:0] acc_n;
  logic        [WIDTH:0]   mult_n;
  logic                    q_n;
  logic      [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             res_exc;
  logic             res_rdy;
  logic             busy_r;

  // Widen an operand by one bit: zero-extend for unsigned, sign-extend for signed.
  function automatic logic [WIDTH:0] ext_op(input logic [WIDTH-1:0] v, input logic uns);
    return uns ? {1'b0, v} : {v[WIDTH-1], v};
  endfunction

  // Exact overflow: signed needs the top WIDTH+1 bits uniform; unsigned needs a zero high word.
  function automatic logic ovf_check(input logic [2*WIDTH-1:0] p, input logic uns);
    if (uns)
      return |p[2*WIDTH-1:WIDTH];
    else
      return (|p[2*WIDTH-1:WIDTH-1]) && !(&p[2*WIDTH-1:WIDTH-1]);
  endfunction

  // One Booth step (add/subtract/no-op on {mult[0], q}) followed by an arithmetic right shift.
  always_comb begin
    acc_sum = acc;
    case ({mult[0], q})
      2'b01:   acc_sum = acc + mcand;
      2'b10:   acc_sum = acc - mcand;
      default: acc_sum = acc;
    endcase
    acc_n  = {acc_sum[WIDTH+1], acc_sum[WIDTH+1:1]};
    mult_n = {acc_sum[0], mult[WIDTH:1]};
    q_n    = mult[0];
    prod   = {acc_n[WIDTH-2:0], mult_n};
  end

  // Control FSM and datapath registers; outputs are loaded on the final step edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mult    <= '0;
      q       <= 1'b0;
      mode    <= 1'b0;
      res_lo  <= '0;
      res_hi  <= '0;
      res_exc <= 1'b0;
      res_rdy <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      res_rdy <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.ctrl_MULT) begin
            logic [WIDTH:0] a_ext;
            a_ext  = ext_op(bus.data_operandA, bus.mode_unsigned);
            mcand  <= {a_ext[WIDTH], a_ext};
            mult   <= ext_op(bus.data_operandB, bus.mode_unsigned);
            mode   <= bus.mode_unsigned;
            acc    <= '0;
            q      <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc  <= acc_n;
          mult <= mult_n;
          q    <= q_n;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH)) begin
            res_lo  <= prod[WIDTH-1:0];
            res_hi  <= prod[2*WIDTH-1:WIDTH];
            res_exc <= ovf_check(prod, mode);
            res_rdy <= 1'b1;
            busy_r  <= 1'b0;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_result    = res_lo;
  assign bus.data_result_hi = res_hi;
  assign bus.data_exception = res_exc;
  assign bus.data_resultRDY = res_rdy;
  assign bus.busy           = busy_r;

endmodule

// File: tb/tb_mult_seq_ovf.sv
// Directed bench for mult_seq_ovf: a 32-bit and an 8-bit instance, hand-computed products.
module tb_mult_seq_ovf;

  logic clk = 1'b0;
  logic rst32 = 1'b1;
  logic rst8  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc;

  always #5 clk = ~clk;

  mult_seq_ovf_if #(.WIDTH(32)) b32 ();
  mult_seq_ovf_if #(.WIDTH(8))  b8 ();

  mult_seq_ovf #(.WIDTH(32)) dut32 (.clock(clk), .reset(rst32), .bus(b32.slave));
  mult_seq_ovf #(.WIDTH(8))  dut8  (.clock(clk), .reset(rst8),  .bus(b8.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present strobe for one edge (E0), return at the following negedge.
  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic uns);
    b32.ctrl_MULT = 1'b1; b32.data_operandA = a; b32.data_operandB = b; b32.mode_unsigned = uns;
    @(negedge clk);
    b32.ctrl_MULT = 1'b0; b32.data_operandA = '1; b32.data_operandB = '1; b32.mode_unsigned = ~uns;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic uns);
    b8.ctrl_MULT = 1'b1; b8.data_operandA = a; b8.data_operandB = b; b8.mode_unsigned = uns;
    @(negedge clk);
    b8.ctrl_MULT = 1'b0; b8.data_operandA = '1; b8.data_operandB = '1; b8.mode_unsigned = ~uns;
  endtask

  // Count edges after E0 until RDY is seen (bounded).
  task automatic wait32(output int n);
    n = 0;
    while (b32.data_resultRDY !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic wait8(output int n);
    n = 0;
    while (b8.data_resultRDY !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic res32(input string tag, input logic [31:0] lo, input logic [31:0] hi, input logic exc);
    chk({tag, ".lo"},  64'(b32.data_result),    64'(lo));
    chk({tag, ".hi"},  64'(b32.data_result_hi), 64'(hi));
    chk({tag, ".exc"}, 64'(b32.data_exception), 64'(exc));
  endtask

  task automatic res8(input string tag, input logic [7:0] lo, input logic [7:0] hi, input logic exc);
    chk({tag, ".lo"},  64'(b8.data_result),    64'(lo));
    chk({tag, ".hi"},  64'(b8.data_result_hi), 64'(hi));
    chk({tag, ".exc"}, 64'(b8.data_exception), 64'(exc));
  endtask

  initial begin
    int seen_rdy;
    b32.ctrl_MULT = 1'b0; b32.mode_unsigned = 1'b0; b32.data_operandA = '0; b32.data_operandB = '0;
    b8.ctrl_MULT  = 1'b0; b8.mode_unsigned  = 1'b0; b8.data_operandA  = '0; b8.data_operandB  = '0;
    repeat (3) @(negedge clk);
    rst32 = 1'b0; rst8 = 1'b0;

    // Reset state
    res32("reset", 32'h0, 32'h0, 1'b0);
    chk("reset.rdy",  64'(b32.data_resultRDY), 64'(0));
    chk("reset.busy", 64'(b32.busy), 64'(0));

    // Test 1: 3*4 signed, latency 33
    start32(32'd3, 32'd4, 1'b0);
    chk("t1.busy", 64'(b32.busy), 64'(1));
    wait32(cyc);
    chk("t1.lat", 64'(cyc), 64'(33));
    res32("t1", 32'h0000000C, 32'h0, 1'b0);
    chk("t1.busy_done", 64'(b32.busy), 64'(0));
    @(negedge clk);
    chk("t1.rdy_pulse", 64'(b32.data_resultRDY), 64'(0));
    repeat (2) @(negedge clk);
    res32("t1.hold", 32'h0000000C, 32'h0, 1'b0);

    // Test 2: signed overflow and mixed-sign
    start32(32'h00010000, 32'h00010000, 1'b0); wait32(cyc);
    res32("t2a", 32'h0, 32'h1, 1'b1);
    @(negedge clk);
    start32(32'hFFFFFFFE, 32'd3, 1'b0); wait32(cyc);
    res32("t2b", 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0);
    @(negedge clk);

    // Test 3: most negative times -1, both modes; -1*-1
    start32(32'h80000000, 32'hFFFFFFFF, 1'b0); wait32(cyc);
    res32("t3s", 32'h80000000, 32'h0, 1'b1);
    @(negedge clk);
    start32(32'h80000000, 32'hFFFFFFFF, 1'b1); wait32(cyc);
    chk("t3u.lat", 64'(cyc), 64'(33));
    res32("t3u", 32'h80000000, 32'h7FFFFFFF, 1'b1);
    @(negedge clk);
    start32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); wait32(cyc);
    res32("t3m1", 32'h1, 32'h0, 1'b0);
    @(negedge clk);

    // Test 4: 8-bit instance
    start8(8'hFF, 8'hFF, 1'b1); wait8(cyc);
    chk("t4.lat", 64'(cyc), 64'(9));
    res8("t4a", 8'h01, 8'hFE, 1'b1);
    @(negedge clk);
    start8(8'h00, 8'hFF, 1'b1); wait8(cyc);
    res8("t4b", 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    start8(8'h0F, 8'h11, 1'b1); wait8(cyc);
    res8("t4u", 8'hFF, 8'h00, 1'b0);
    @(negedge clk);
    start8(8'h0F, 8'h11, 1'b0); wait8(cyc);
    res8("t4s", 8'hFF, 8'h00, 1'b1);
    @(negedge clk);
    start8(8'h80, 8'h01, 1'b0); wait8(cyc);
    res8("t4n", 8'h80, 8'hFF, 1'b0);
    @(negedge clk);

    // Test 5: strobe during RUN ignored; strobe during DONE accepted back-to-back
    start32(32'd5, 32'd7, 1'b0);
    repeat (4) @(negedge clk);
    b32.ctrl_MULT = 1'b1; b32.data_operandA = 32'd9; b32.data_operandB = 32'd9;
    @(negedge clk);
    b32.ctrl_MULT = 1'b0;
    cyc = 0;
    while (b32.data_resultRDY !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("t5.lat", 64'(cyc + 5), 64'(33));
    res32("t5a", 32'd35, 32'h0, 1'b0);
    start32(32'd2, 32'd2, 1'b0);
    chk("t5.b2b_rdy",  64'(b32.data_resultRDY), 64'(0));
    chk("t5.b2b_busy", 64'(b32.busy), 64'(1));
    wait32(cyc);
    chk("t5b.lat", 64'(cyc), 64'(33));
    res32("t5b", 32'd4, 32'h0, 1'b0);
    @(negedge clk);

    // Test 6: reset mid-operation discards it
    start32(32'd6, 32'd6, 1'b0);
    repeat (9) @(negedge clk);
    rst32 = 1'b1;
    @(negedge clk);
    rst32 = 1'b0;
    res32("t6.rst", 32'h0, 32'h0, 1'b0);
    chk("t6.busy", 64'(b32.busy), 64'(0));
    seen_rdy = 0;
    repeat (40) begin
      @(negedge clk);
      if (b32.data_resultRDY === 1'b1) seen_rdy++;
    end
    chk("t6.no_rdy", 64'(seen_rdy), 64'(0));
    start32(32'd6, 32'd7, 1'b0); wait32(cyc);
    chk("t6.lat", 64'(cyc), 64'(33));
    res32("t6.fresh", 32'd42, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_seq_ovf.md
Name: mult_seq_ovf

Overview:
- Parametrised, multicycle multiplier with built-in exact overflow detection; successor to the standalone combinational overflow checker.
- Sits in the execute-stage ALU/multdiv path.
- Accepts a one-cycle start strobe, runs an iterative radix-2 Booth recurrence, then presents the low product word, high product word, overflow flag and a one-cycle ready strobe.
- Supports signed and unsigned modes.

Parameters:
- WIDTH, 32, operand and result word width; legal range 4..64.
- CNT_W, $clog2(WIDTH+2), iteration counter width; derived, not overridden.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
- ctrl_MULT  input  1  start strobe; accepted only when busy=0.
- mode_unsigned  input  1  0 = signed two's-complement, 1 = unsigned; captured with the operands.
- data_operandA  input  WIDTH  multiplicand; captured on the accepting edge.
- data_operandB  input  WIDTH  multiplier; captured on the accepting edge.
- data_result  output  WIDTH  low WIDTH bits of the product.
- data_result_hi  output  WIDTH  high WIDTH bits of the product.
- data_exception  output  1  overflow: the product does not fit in WIDTH bits for the captured mode.
- data_resultRDY  output  1  one-cycle strobe; the outputs above are valid in this cycle and hold until the next accept.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset: state IDLE; counter = 0; accumulator = 0.
- Reset values: data_result = 0, data_result_hi = 0, data_exception = 0, data_resultRDY = 0, busy = 0.
- Reset wins over every other input, including mid-operation. The in-flight op is discarded and no RDY is issued.
- State IDLE:
  - busy = 0.
  - ctrl_MULT = 1 at edge E0: capture A, B and mode, go to RUN, counter = 0.
  - Operands are extended to WIDTH+1 bits: sign-extended if mode_unsigned = 0, zero-extended if 1.
- State RUN:
  - busy = 1.
  - Each edge performs one Booth step on the extended multiplier pair (bit0, previous bit):
    - 01 add multiplicand;
    - 10 subtract multiplicand;
    - 00 / 11 no operation.
  - Then an arithmetic right shift of the {acc, mult, q-1} register.
  - The accumulator is WIDTH+2 bits to absorb the extension.
  - After WIDTH+1 steps (edges E1..E(WIDTH+1)) go to DONE.
- State DONE (a single cycle entered at edge E(WIDTH+1)):
  - Registered outputs are loaded at that same edge.
  - data_resultRDY = 1 and busy = 0 for exactly this cycle.
  - Next edge returns to IDLE.
  - ctrl_MULT = 1 while in DONE is accepted as a new E0, giving back-to-back operation with no bubble.
- Latency: WIDTH+1 cycles from the accepting edge to the RDY cycle, independent of mode and operand values.
- Product: full 2·WIDTH-bit value P (the recurrence yields 2·WIDTH+2 bits; the low 2·WIDTH bits are kept).
  - data_result = P[WIDTH-1:0].
  - data_result_hi = P[2·WIDTH-1:WIDTH].
- Overflow, signed mode: data_exception = 1 iff P[2·WIDTH-1:WIDTH-1] is not all-zeros and not all-ones.
  - Exact rule; it covers the zero-product and mixed-sign cases by construction.
- Overflow, unsigned mode: data_exception = 1 iff data_result_hi ≠ 0.
- ctrl_MULT while in RUN is ignored: no restart, and the operands are not recaptured.
- Operand and mode inputs are don't-care except at the accepting edge.
- Between operations all outputs hold their last values; data_resultRDY = 0 outside DONE.

Test Plan:
1. WIDTH=32, signed, A=3, B=4, strobe at E0 -> RDY exactly 33 cycles later; data_result=0x0000000C, hi=0, exception=0.
2. WIDTH=32, signed, A=0x00010000, B=0x00010000 -> data_result=0, hi=0x00000001, exception=1; repeat with A=0xFFFFFFFE (-2), B=3 -> data_result=0xFFFFFFFA, hi=0xFFFFFFFF, exception=0.
3. WIDTH=32, A=0x80000000, B=0xFFFFFFFF:
   - signed -> data_result=0x80000000, hi=0, exception=1;
   - unsigned -> data_result=0x80000000, hi=0x7FFFFFFF, exception=1.
   - Also signed A=-1, B=-1 -> data_result=1, exception=0.
4. WIDTH=8, unsigned, A=0xFF, B=0xFF -> RDY after 9 cycles, data_result=0x01, hi=0xFE, exception=1; A=0, B=0xFF -> all zero, exception=0.
5. Start A=5, B=7, then pulse ctrl_MULT with A=9 mid-RUN -> ignored, result 35 at the original RDY cycle. Strobe A=2, B=2 during the RDY cycle -> accepted, result 4 exactly WIDTH+1 cycles later.
6. Assert reset at cycle 10 of an operation -> next cycle all outputs 0, busy=0, no RDY ever appears for that op; a fresh strobe afterwards completes normally.
